// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU-control decode and operand forwarding
// Holds one decoded instruction; operands are forwarded combinationally from EX/MEM and MEM/WB.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic            alu_src,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic            out_valid,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_q,
    output logic            reg_write_q,
    output logic            mem_read_q,
    output logic            mem_write_q,
    output logic            illegal
);

    logic            r_valid;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [4:0]      r_rd;
    logic            r_alu_src;
    logic [3:0]      r_alu_ctrl;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_illegal;

    logic [3:0]      w_alu_ctrl;
    logic            w_illegal;
    logic [XLEN-1:0] w_fwd1;
    logic [XLEN-1:0] w_fwd2;

    assign in_ready = !stall && !flush;

    always_comb begin
        w_alu_ctrl = 4'b0010;
        w_illegal  = 1'b0;
        case (alu_op)
            2'b00: w_alu_ctrl = 4'b0010;
            2'b01: w_alu_ctrl = 4'b0110;
            default: begin
                // funct7b5 only selects SUB for R-type; I-type ignores it
                case (funct3)
                    3'b000:  w_alu_ctrl = (alu_op == 2'b10 && funct7b5) ? 4'b0110 : 4'b0010;
                    3'b111:  w_alu_ctrl = 4'b0000;
                    3'b110:  w_alu_ctrl = 4'b0001;
                    3'b010:  w_alu_ctrl = 4'b0111;
                    default: begin
                        w_alu_ctrl = 4'b0010;
                        w_illegal  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd        <= '0;
            r_alu_src   <= 1'b0;
            r_alu_ctrl  <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush || (!stall && !in_valid)) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (!stall) begin
            r_valid     <= 1'b1;
            r_rs1_data  <= rs1_data;
            r_rs2_data  <= rs2_data;
            r_imm       <= imm;
            r_rs1_addr  <= rs1_addr;
            r_rs2_addr  <= rs2_addr;
            r_rd        <= rd_addr;
            r_alu_src   <= alu_src;
            r_alu_ctrl  <= w_alu_ctrl;
            r_reg_write <= reg_write && !w_illegal;
            r_mem_read  <= mem_read && !w_illegal;
            r_mem_write <= mem_write && !w_illegal;
            r_illegal   <= w_illegal;
        end
    end

    // x0 is hardwired zero, so it is never a forwarding target
    always_comb begin
        w_fwd1 = r_rs1_data;
        if (exmem_reg_write && exmem_rd == r_rs1_addr && r_rs1_addr != 5'd0)
            w_fwd1 = exmem_result;
        else if (memwb_reg_write && memwb_rd == r_rs1_addr && r_rs1_addr != 5'd0)
            w_fwd1 = memwb_result;
    end

    always_comb begin
        w_fwd2 = r_rs2_data;
        if (exmem_reg_write && exmem_rd == r_rs2_addr && r_rs2_addr != 5'd0)
            w_fwd2 = exmem_result;
        else if (memwb_reg_write && memwb_rd == r_rs2_addr && r_rs2_addr != 5'd0)
            w_fwd2 = memwb_result;
    end

    assign out_valid   = r_valid;
    assign operand1    = w_fwd1;
    assign operand2    = r_alu_src ? r_imm : w_fwd2;
    assign store_data  = w_fwd2;
    assign alu_control = r_alu_ctrl;
    assign rd_q        = r_rd;
    assign reg_write_q = r_reg_write;
    assign mem_read_q  = r_mem_read;
    assign mem_write_q = r_mem_write;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, stall, flush;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7b5, reg_write, mem_read, mem_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic        out_valid;
    logic [31:0] operand1, operand2, store_data;
    logic [3:0]  alu_control;
    logic [4:0]  rd_q;
    logic        reg_write_q, mem_read_q, mem_write_q, illegal;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .alu_src(alu_src), .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .out_valid(out_valid), .operand1(operand1), .operand2(operand2),
        .alu_control(alu_control), .store_data(store_data), .rd_q(rd_q),
        .reg_write_q(reg_write_q), .mem_read_q(mem_read_q), .mem_write_q(mem_write_q),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv, st, fl;
        logic [31:0] r1d, r2d, imm;
        logic [4:0]  r1a, r2a, rd;
        logic        asrc;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7, rw, mr, mw;
        logic [4:0]  exrd, wbrd;
        logic        exrw, wbrw;
        logic [31:0] exres, wbres;
    } in_t;

    // Instruction the stage should be holding; known=0 when data fields are unspecified
    typedef struct {
        logic        v, known, ill, rw, mr, mw, asrc;
        logic [3:0]  ctrl;
        logic [31:0] r1d, r2d, imm;
        logic [4:0]  r1a, r2a, rd;
    } held_t;

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] ctrl;
        logic       ill;
    } vec_t;

    in_t   cur;
    held_t m;
    vec_t  vt[14];
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        in_valid = cur.iv; stall = cur.st; flush = cur.fl;
        rs1_data = cur.r1d; rs2_data = cur.r2d; imm = cur.imm;
        rs1_addr = cur.r1a; rs2_addr = cur.r2a; rd_addr = cur.rd;
        alu_src = cur.asrc; alu_op = cur.op; funct3 = cur.f3; funct7b5 = cur.f7;
        reg_write = cur.rw; mem_read = cur.mr; mem_write = cur.mw;
        exmem_rd = cur.exrd; exmem_reg_write = cur.exrw; exmem_result = cur.exres;
        memwb_rd = cur.wbrd; memwb_reg_write = cur.wbrw; memwb_result = cur.wbres;
    endtask

    function automatic void decode(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                   output logic [3:0] ctrl, output logic ill);
        ill = 1'b0;
        ctrl = 4'b0010;
        if (op == 2'b01) ctrl = 4'b0110;
        else if (op != 2'b00) begin
            if (f3 == 3'b000) ctrl = (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
            else if (f3 == 3'b111) ctrl = 4'b0000;
            else if (f3 == 3'b110) ctrl = 4'b0001;
            else if (f3 == 3'b010) ctrl = 4'b0111;
            else ill = 1'b1;
        end
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
        if (a != 0 && cur.exrw && cur.exrd == a) return cur.exres;
        if (a != 0 && cur.wbrw && cur.wbrd == a) return cur.wbres;
        return d;
    endfunction

    task automatic model_reset();
        m = '{default: '0};
        m.known = 1'b1;
    endtask

    task automatic model_edge();
        logic [3:0] c;
        logic       il;
        if (!rst_n) model_reset();
        else if (cur.fl || (!cur.st && !cur.iv)) begin
            m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.ill = 0; m.known = 0;
        end else if (!cur.st) begin
            decode(cur.op, cur.f3, cur.f7, c, il);
            m.v = 1; m.known = 1; m.ctrl = c; m.ill = il;
            m.rw = cur.rw & ~il; m.mr = cur.mr & ~il; m.mw = cur.mw & ~il;
            m.r1d = cur.r1d; m.r2d = cur.r2d; m.imm = cur.imm;
            m.r1a = cur.r1a; m.r2a = cur.r2a; m.rd = cur.rd; m.asrc = cur.asrc;
        end
    endtask

    task automatic check_all();
        chk("out_valid", out_valid, m.v);
        chk("reg_write_q", reg_write_q, m.rw);
        chk("mem_read_q", mem_read_q, m.mr);
        chk("mem_write_q", mem_write_q, m.mw);
        chk("illegal", illegal, m.ill);
        chk("in_ready", in_ready, !(cur.st || cur.fl));
        if (m.known) begin
            chk("operand1", operand1, fwd(m.r1a, m.r1d));
            chk("operand2", operand2, m.asrc ? m.imm : fwd(m.r2a, m.r2d));
            chk("store_data", store_data, fwd(m.r2a, m.r2d));
            chk("alu_control", alu_control, m.ctrl);
            chk("rd_q", rd_q, m.rd);
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        chk("in_ready_pre", in_ready, !(cur.st || cur.fl));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic base();
        cur = '{default: '0};
        cur.iv = 1; cur.r1d = 32'd10; cur.r2d = 32'd3;
        cur.r1a = 5'd1; cur.r2a = 5'd2; cur.rd = 5'd3; cur.rw = 1;
    endtask

    initial begin
        vt[0]  = '{2'b00, 3'b000, 1'b0, 4'b0010, 1'b0};
        vt[1]  = '{2'b01, 3'b101, 1'b1, 4'b0110, 1'b0};
        vt[2]  = '{2'b10, 3'b000, 1'b0, 4'b0010, 1'b0};
        vt[3]  = '{2'b10, 3'b000, 1'b1, 4'b0110, 1'b0};
        vt[4]  = '{2'b10, 3'b111, 1'b0, 4'b0000, 1'b0};
        vt[5]  = '{2'b10, 3'b110, 1'b1, 4'b0001, 1'b0};
        vt[6]  = '{2'b10, 3'b010, 1'b0, 4'b0111, 1'b0};
        vt[7]  = '{2'b10, 3'b001, 1'b0, 4'b0010, 1'b1};
        vt[8]  = '{2'b10, 3'b101, 1'b1, 4'b0010, 1'b1};
        vt[9]  = '{2'b11, 3'b000, 1'b1, 4'b0010, 1'b0};
        vt[10] = '{2'b11, 3'b111, 1'b0, 4'b0000, 1'b0};
        vt[11] = '{2'b11, 3'b110, 1'b0, 4'b0001, 1'b0};
        vt[12] = '{2'b11, 3'b010, 1'b1, 4'b0111, 1'b0};
        vt[13] = '{2'b11, 3'b011, 1'b0, 4'b0010, 1'b1};

        // reset state
        rst_n = 1'b0;
        cur = '{default: '0};
        model_reset();
        cycle();
        chk("rst_operand1", operand1, 32'd0);
        chk("rst_alu_control", alu_control, 4'd0);
        rst_n = 1'b1;

        // decode table, also covers R-type SUB and illegal funct3
        for (int i = 0; i < 14; i++) begin
            base();
            cur.op = vt[i].op; cur.f3 = vt[i].f3; cur.f7 = vt[i].f7;
            cycle();
            chk("tbl_ctrl", alu_control, vt[i].ctrl);
            chk("tbl_illegal", illegal, vt[i].ill);
            chk("tbl_reg_write_q", reg_write_q, !vt[i].ill);
            chk("tbl_operand1", operand1, 32'd10);
            chk("tbl_operand2", operand2, 32'd3);
        end

        // double forward: EX/MEM wins, x0 never forwarded
        base(); cur.r1a = 5'd5;
        cycle();
        cur.exrd = 5'd5; cur.exrw = 1; cur.exres = 32'hAA;
        cur.wbrd = 5'd5; cur.wbrw = 1; cur.wbres = 32'hBB;
        drive(); #1;
        chk("dfwd_op1", operand1, 32'hAA);
        cur.exrw = 0; drive(); #1;
        chk("memwb_op1", operand1, 32'hBB);
        base(); cur.r1a = 5'd0; cur.r1d = 32'h1234;
        cur.exrd = 5'd0; cur.exrw = 1; cur.exres = 32'hAA;
        cur.wbrd = 5'd0; cur.wbrw = 1; cur.wbres = 32'hBB;
        cycle();
        chk("x0_op1", operand1, 32'h1234);

        // stall+flush together drops the held instruction
        base(); cycle();
        cur.st = 1; cur.fl = 1;
        drive(); #1;
        chk("sf_in_ready", in_ready, 1'b0);
        @(posedge clk); model_edge(); #1;
        check_all();
        chk("sf_out_valid", out_valid, 1'b0);
        chk("sf_reg_write_q", reg_write_q, 1'b0);

        // ADDI held under stall with changing EX/MEM forward
        base(); cur.op = 2'b11; cur.asrc = 1; cur.imm = 32'hFFFF_FFFF; cur.r1a = 5'd7;
        cycle();
        for (int i = 0; i < 3; i++) begin
            cur.st = 1; cur.iv = (i != 1);
            cur.exrd = 5'd7; cur.exrw = 1; cur.exres = 32'h100 + 32'(i * 17);
            cycle();
            chk("stall_op2", operand2, 32'hFFFF_FFFF);
            chk("stall_op1", operand1, 32'h100 + 32'(i * 17));
            chk("stall_valid", out_valid, 1'b1);
        end

        // asynchronous reset mid-cycle, then recovery
        base(); cur.r1d = 32'h55; cycle();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_op1", operand1, 32'd0);
        chk("arst_op2", operand2, 32'd0);
        chk("arst_store", store_data, 32'd0);
        cycle();
        rst_n = 1'b1;
        base(); cur.r1d = 32'h77;
        cycle();
        chk("rec_valid", out_valid, 1'b1);
        chk("rec_op1", operand1, 32'h77);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cur.iv = ($urandom_range(3) != 0);
            cur.st = ($urandom_range(3) == 0);
            cur.fl = ($urandom_range(9) == 0);
            cur.r1d = $urandom; cur.r2d = $urandom; cur.imm = $urandom;
            cur.r1a = 5'($urandom_range(3)); cur.r2a = 5'($urandom_range(3));
            cur.rd = 5'($urandom);
            cur.asrc = 1'($urandom); cur.op = 2'($urandom); cur.f3 = 3'($urandom);
            cur.f7 = 1'($urandom); cur.rw = 1'($urandom); cur.mr = 1'($urandom);
            cur.mw = 1'($urandom);
            cur.exrd = 5'($urandom_range(3)); cur.wbrd = 5'($urandom_range(3));
            cur.exrw = 1'($urandom); cur.wbrw = 1'($urandom);
            cur.exres = $urandom; cur.wbres = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
